vend_payout: RTL and testbench

VEND_PAYOUT -- requirements
Module: vend_payout

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_evt_fifo.sv | 62 ++++++
 rtl/vend_payout.sv | 132 +++++++++++++
 tb/tb_vend_payout.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vend payout block: FSM states, change codes
// (units of one 0.5-yuan coin) and default queue depth / watchdog limit.
package vend_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 200;

  typedef enum logic [1:0] {
    CHG_0  = 2'd0,
    CHG_05 = 2'd1,
    CHG_10 = 2'd2,
    CHG_15 = 2'd3
  } change_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEND     = 3'd1,
    PAY      = 3'd2,
    PAY_WAIT = 3'd3,
    FAULT    = 3'd4
  } state_e;

endpackage

// File: rtl/vend_evt_fifo.sv
// Pending vend-event queue (2-bit change code per entry), first-word fall-through head.
// Push into a full queue is accepted only when a pop happens on the same edge.
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [1:0]               push_dat_i,
  input  logic                     pop_i,
  output logic [1:0]               head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o      = (cnt_q == FULL_CNT);
  assign empty_o     = (cnt_q == '0);
  assign pop_ok      = pop_i && !empty_o;
  assign push_ok     = push_i && (!full_o || pop_ok);
  assign head_dat_o  = mem_q[rd_q];
  assign count_o     = cnt_q;
  assign count_nxt_o = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/vend_payout.sv
// Beverage motor + coin hopper sequencer fed from a queue of vend events.
// Motor starts one edge after a dispense into an idle block; all outputs registered.
module vend_payout
  import vend_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          dispense,
  input  logic [1:0]                    change,
  output logic                          motor_on,
  input  logic                          motor_done,
  output logic                          hopper_pulse,
  input  logic                          hopper_ack,
  input  logic                          clear_fault,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow,
  output logic                          fault
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                      state_q, state_d;
  logic [1:0]                  coins_q, coins_d;
  logic [7:0]                  tmo_q, tmo_d;
  logic                        pop, fifo_full, fifo_empty, drop;
  logic [1:0]                  head_dat;
  logic [$clog2(FIFO_DEPTH):0] cnt_nxt;
  logic                        motor_on_q, hopper_pulse_q, busy_q, overflow_q, fault_q;

  vend_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (dispense),
    .push_dat_i  (change),
    .pop_i       (pop),
    .head_dat_o  (head_dat),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (pending),
    .count_nxt_o (cnt_nxt)
  );

  assign drop = dispense && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    coins_d = coins_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          coins_d = head_dat;
          tmo_d   = '0;
          state_d = VEND;
        end
      end
      VEND: begin
        if (motor_done) begin
          tmo_d   = '0;
          state_d = (coins_q != 2'(CHG_0)) ? PAY : IDLE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          coins_d = '0;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      PAY: begin
        tmo_d   = '0;
        state_d = PAY_WAIT;
      end
      PAY_WAIT: begin
        if (hopper_ack) begin
          tmo_d   = '0;
          coins_d = coins_q - 2'd1;
          state_d = (coins_q == 2'd1) ? IDLE : PAY;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          coins_d = '0;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      FAULT: begin
        if (clear_fault) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      coins_q        <= '0;
      tmo_q          <= '0;
      motor_on_q     <= 1'b0;
      hopper_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      coins_q        <= coins_d;
      tmo_q          <= tmo_d;
      motor_on_q     <= (state_d == VEND);
      hopper_pulse_q <= (state_d == PAY);
      fault_q        <= (state_d == FAULT);
      busy_q         <= (state_d != IDLE) || (cnt_nxt != '0);
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_fault) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign motor_on     = motor_on_q;
  assign hopper_pulse = hopper_pulse_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vend_payout.sv
// Scoreboard bench for vend_payout: queued change codes are matched against the
// hopper pulses of each vend, with motor/hopper responders driving done/ack.
module tb_vend_payout;

  logic       clk, reset_n, dispense, motor_done, hopper_ack, clear_fault;
  logic [1:0] change;
  logic       motor_on, hopper_pulse, busy, overflow, fault;
  logic [2:0] pending;

  vend_payout dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dispense     (dispense),
    .change       (change),
    .motor_on     (motor_on),
    .motor_done   (motor_done),
    .hopper_pulse (hopper_pulse),
    .hopper_ack   (hopper_ack),
    .clear_fault  (clear_fault),
    .busy         (busy),
    .pending      (pending),
    .overflow     (overflow),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] exp_q [$];
  int coins_exp = 0;
  int vends = 0, pulses = 0, last_mlen = 0;
  int motor_dly = 3, ack_dly = 2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Motor: raises motor_done for one cycle after motor_dly cycles of motor_on (0 = stalled).
  initial begin
    int mcnt = 0;
    motor_done = 1'b0;
    forever begin
      @(negedge clk);
      motor_done = 1'b0;
      if (motor_on && motor_dly != 0) begin
        mcnt++;
        if (mcnt == motor_dly) motor_done = 1'b1;
      end else begin
        mcnt = 0;
      end
    end
  end

  // Hopper: one-cycle ack ack_dly cycles after each pulse (0 = never acks).
  initial begin
    int hwait = 0;
    hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      hopper_ack = 1'b0;
      if (!reset_n) begin
        hwait = 0;
      end else if (hopper_pulse) begin
        hwait = ack_dly;
      end else if (hwait != 0) begin
        hwait--;
        if (hwait == 0) hopper_ack = 1'b1;
      end
    end
  end

  // Monitor: each motor_on rise starts the next scoreboard entry; pulses consume its coins.
  initial begin
    logic prev_motor = 1'b0, prev_pulse = 1'b0, outstanding = 1'b0;
    int   mlen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev_motor  = 1'b0;
        prev_pulse  = 1'b0;
        outstanding = 1'b0;
      end else begin
        if (hopper_ack) outstanding = 1'b0;
        if (motor_on && !prev_motor) begin
          chk("sb_entry_avail", 32'(exp_q.size() != 0), 32'd1);
          chk("prev_vend_paid", 32'(coins_exp), 32'd0);
          if (exp_q.size() != 0) coins_exp = int'(exp_q.pop_front());
          vends++;
          mlen = 0;
        end
        if (motor_on) mlen++;
        if (!motor_on && prev_motor) last_mlen = mlen;
        if (hopper_pulse) begin
          chk("pulse_one_cycle", 32'(prev_pulse), 32'd0);
          chk("pulse_after_ack", 32'(outstanding), 32'd0);
          chk("pulse_owed", 32'(coins_exp != 0), 32'd1);
          if (coins_exp != 0) coins_exp--;
          outstanding = 1'b1;
          pulses++;
        end
        prev_motor = motor_on;
        prev_pulse = hopper_pulse;
      end
    end
  end

  task automatic do_vend(input logic [1:0] c);
    @(negedge clk);
    dispense = 1'b1;
    change   = c;
    exp_q.push_back(c);
    @(negedge clk);
    dispense = 1'b0;
    change   = 2'($urandom);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < budget);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_motor"}, 32'(motor_on), 32'd0);
    chk({tag, "_hopper"}, 32'(hopper_pulse), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  logic [1:0] chg6 [6] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2};

  initial begin
    int p0, v0, n;
    reset_n = 1'b0; dispense = 1'b0; change = 2'd0; clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_low("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // change=0, motor_done after 3 cycles: first-vend latency and motor width
    p0 = pulses;
    @(negedge clk);
    dispense = 1'b1; change = 2'd0; exp_q.push_back(2'd0);
    @(posedge clk); #1;
    chk("lat_motor_off", 32'(motor_on), 32'd0);
    chk("lat_pending1", 32'(pending), 32'd1);
    @(negedge clk);
    dispense = 1'b0; change = 2'd3;
    @(posedge clk); #1;
    chk("lat_motor_on", 32'(motor_on), 32'd1);
    chk("lat_pending0", 32'(pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("c0_motor_still_on", 32'(motor_on), 32'd1);
    @(posedge clk); #1;
    chk("c0_motor_off", 32'(motor_on), 32'd0);
    chk("c0_busy_off", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    chk("c0_motor_len", 32'(last_mlen), 32'd3);
    chk("c0_no_pulse", 32'(pulses - p0), 32'd0);

    // change=1: one coin
    p0 = pulses;
    do_vend(2'd1);
    wait_idle("c1_idle", 100);
    chk("c1_pulses", 32'(pulses - p0), 32'd1);

    // change=3 with acks two cycles after each pulse
    p0 = pulses;
    do_vend(2'd3);
    wait_idle("c3_idle", 100);
    chk("c3_pulses", 32'(pulses - p0), 32'd3);
    chk("c3_coins_left", 32'(coins_exp), 32'd0);

    // six back-to-back dispenses with the motor stalled: first popped, four queued, last dropped
    p0 = pulses; v0 = vends;
    motor_dly = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dispense = 1'b1;
      change   = chg6[i];
      if (i < 5) exp_q.push_back(chg6[i]);
    end
    @(negedge clk);
    dispense = 1'b0;
    chk("ovf_pending4", 32'(pending), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_motor_on", 32'(motor_on), 32'd1);
    motor_dly = 2;
    wait_idle("ovf_drain_idle", 300);
    chk("ovf_pulses", 32'(pulses - p0), 32'd7);
    chk("ovf_vends", 32'(vends - v0), 32'd5);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_no_fault", 32'(fault), 32'd0);

    // motor never finishes: fault after TIMEOUT cycles of motor_on
    motor_dly = 0;
    do_vend(2'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!fault && n < 400);
    chk("tmo_cycles", 32'(n), 32'd201);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_motor_off", 32'(motor_on), 32'd0);
    coins_exp = 0;
    p0 = pulses;
    do_vend(2'd2);
    chk("tmo_queued_in_fault", 32'(pending), 32'd1);
    chk("tmo_fault_held", 32'(fault), 32'd1);
    motor_dly = 2;
    pulse_clear();
    wait_idle("tmo_resume_idle", 100);
    chk("tmo_fault_cleared", 32'(fault), 32'd0);
    chk("tmo_resume_pulses", 32'(pulses - p0), 32'd2);

    // reset in PAY_WAIT with two events queued
    p0 = pulses;
    ack_dly = 0;
    do_vend(2'd3);
    do_vend(2'd1);
    do_vend(2'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending2", 32'(pending), 32'd2);
    chk("rst_one_pulse", 32'(pulses - p0), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_low("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    coins_exp = 0;
    ack_dly = 2;
    p0 = pulses; v0 = vends;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_pulse", 32'(pulses - p0), 32'd0);
    chk("rst_no_vend", 32'(vends - v0), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    do_vend(2'd1);
    wait_idle("rst_new_idle", 100);
    chk("rst_new_pulses", 32'(pulses - p0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
